// File: rtl/instr_fetch_unit.sv
// Fetch unit: latches the PC, issues a single-beat memory read, and holds the word for the decoder.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count/stall_count performance counters.
module instr_fetch_unit #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_increment,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  input  logic              instr_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       stall_count
`endif
);

  typedef enum logic [2:0] {IDLE, LATCH, REQ, VALID, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              inc_q;

  // A flush in the first VALID cycle suppresses the pulse so the PC load wins.
  assign pc_increment = inc_q & ~flush;
  assign mem_addr     = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      instr       <= '0;
      inc_q       <= 1'b0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      inc_q <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_en) state <= LATCH;
        end
        LATCH: begin
          addr_q <= pc_addr;
          if (!flush) begin
            mem_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (flush) begin
              state <= LATCH;
            end else begin
              instr       <= mem_rdata;
              inc_q       <= 1'b1;
              instr_valid <= 1'b1;
              state       <= VALID;
            end
          end else if (flush) begin
            // The request cannot be withdrawn; wait it out and drop the data.
            state <= DRAIN;
          end
        end
        VALID: begin
          if (flush) begin
            instr_valid <= 1'b0;
            state       <= LATCH;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= fetch_en ? LATCH : IDLE;
          end
        end
        DRAIN: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= LATCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (state == VALID && instr_ready)
        fetch_count <= fetch_count + 16'd1;
      if ((state == REQ || state == DRAIN) && !mem_ready)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic against an obligation model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fetch_en = 1'b0;
  logic              flush = 1'b0;
  logic              mem_ready = 1'b0;
  logic              instr_ready = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_init = '0;
  logic [ADDR_W-1:0] new_pc = '0;
  logic              pc_increment;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]       fetch_count;
  logic [15:0]       stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_en     (fetch_en),
    .flush        (flush),
    .pc_addr      (pc),
    .pc_increment (pc_increment),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .stall_count  (stall_count)
`endif
  );

  // Environment PC plus the outstanding obligations of the fetch unit:
  // m_out: a read is outstanding (to m_addr), m_stale: its data must be dropped,
  // m_hold: a word (m_instr) must be presented, m_first: its pulse is still owed,
  // m_latch: the PC is sampled at the end of this cycle.
  logic              m_out, m_stale, m_hold, m_first, m_latch;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_instr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= pc_init;
      m_out <= 1'b0; m_stale <= 1'b0; m_hold <= 1'b0; m_first <= 1'b0; m_latch <= 1'b0;
      m_addr <= '0; m_instr <= '0;
    end else begin
      if (flush) pc <= new_pc;
      else if (pc_increment) pc <= pc + 1'b1;
      if (m_out) begin
        if (mem_ready) begin
          m_out <= 1'b0;
          if (m_stale || flush) m_latch <= 1'b1;
          else begin m_hold <= 1'b1; m_first <= 1'b1; m_instr <= mem_rdata; end
        end else if (flush) m_stale <= 1'b1;
      end else if (m_hold) begin
        m_first <= 1'b0;
        if (flush) begin m_hold <= 1'b0; m_latch <= 1'b1; end
        else if (instr_ready) begin m_hold <= 1'b0; m_latch <= fetch_en; end
      end else if (m_latch) begin
        if (!flush) begin m_latch <= 1'b0; m_out <= 1'b1; m_stale <= 1'b0; m_addr <= pc; end
      end else if (fetch_en) m_latch <= 1'b1;
    end
  end

  task automatic apply_reset(input logic [ADDR_W-1:0] start_pc);
    fetch_en = 1'b0; flush = 1'b0; mem_ready = 1'b0; instr_ready = 1'b0;
    mem_rdata = '0; new_pc = '0; pc_init = start_pc;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pc_init = '0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (pc_increment !== 1'b0) begin errors++; $display("FAIL reset_pc_inc got=%b exp=0", pc_increment); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (mem_addr !== 14'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (instr !== 16'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", instr); end
    @(posedge clk); #1 rst_n = 1'b1;
    flush = 1'b1; new_pc = 14'h0077;
    repeat (3) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL idle_quiet got req=%b vld=%b exp 0 0", mem_req, instr_valid);
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
  endtask

  task automatic test_basic();
    int reqs = 0, pulses = 0, n = 0;
    logic prev_req = 1'b0, got = 1'b0;
    apply_reset(14'h2000);
    fetch_en = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hA5A5; instr_ready = 1'b1;
    while (reqs < 2 && n < 20) begin
      @(negedge clk); n++;
      if (pc_increment) pulses++;
      if (instr_valid && !got) begin
        got = 1'b1;
        checks++; if (instr !== 16'hA5A5) begin errors++; $display("FAIL basic_instr got=%h exp=a5a5", instr); end
      end
      if (mem_req && !prev_req) begin
        reqs++;
        if (reqs == 1) begin
          checks++; if (mem_addr !== 14'h2000) begin errors++; $display("FAIL basic_addr0 got=%h exp=2000", mem_addr); end
        end else begin
          checks++; if (mem_addr !== 14'h2001) begin errors++; $display("FAIL basic_addr1 got=%h exp=2001", mem_addr); end
          checks++; if (pulses != 1) begin errors++; $display("FAIL basic_pulses got=%0d exp=1", pulses); end
        end
      end
      prev_req = mem_req;
    end
    checks++; if (reqs < 2 || !got) begin errors++; $display("FAIL basic_timeout got reqs=%0d exp=2", reqs); end
    fetch_en = 1'b0;
  endtask

  task automatic test_mem_stall();
    int n = 0;
    apply_reset(14'h0123);
    fetch_en = 1'b1; mem_ready = 1'b0; instr_ready = 1'b1; mem_rdata = 16'h5A5A;
    do begin @(negedge clk); n++; end while (!mem_req && n < 10);
    checks++; if (!mem_req) begin errors++; $display("FAIL stall_timeout got req=0 exp=1"); end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (i == 5) mem_ready = 1'b1;
        @(negedge clk);
      end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h0123 || pc_increment !== 1'b0) begin
        errors++; $display("FAIL stall_hold got req=%b addr=%h inc=%b exp 1 0123 0", mem_req, mem_addr, pc_increment);
      end
    end
    @(posedge clk); #1 mem_ready = 1'b0; fetch_en = 1'b0;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || pc_increment !== 1'b1 || instr !== 16'h5A5A) begin
      errors++; $display("FAIL stall_done got vld=%b inc=%b instr=%h exp 1 1 5a5a", instr_valid, pc_increment, instr);
    end
  endtask

  task automatic test_decoder_stall();
    int n = 0;
    apply_reset(14'h0040);
    fetch_en = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h1234; instr_ready = 1'b0;
    do begin @(negedge clk); n++; end while (!instr_valid && n < 10);
    checks++; if (instr_valid !== 1'b1 || pc_increment !== 1'b1 || instr !== 16'h1234) begin
      errors++; $display("FAIL dstall_first got vld=%b inc=%b instr=%h exp 1 1 1234", instr_valid, pc_increment, instr);
    end
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1 mem_rdata = 16'hFFFF;
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr !== 16'h1234 || pc_increment !== 1'b0 || mem_req !== 1'b0) begin
        errors++; $display("FAIL dstall_hold got vld=%b instr=%h inc=%b req=%b exp 1 1234 0 0", instr_valid, instr, pc_increment, mem_req);
      end
    end
    @(posedge clk); #1 instr_ready = 1'b1; fetch_en = 1'b0;
    @(posedge clk); #1 instr_ready = 1'b0;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL dstall_idle got vld=%b req=%b exp 0 0", instr_valid, mem_req);
    end
  endtask

  task automatic test_flush_req();
    int n = 0, bad = 0;
    apply_reset(14'h0500);
    fetch_en = 1'b1; mem_ready = 1'b0; instr_ready = 1'b1;
    do begin @(negedge clk); n++; end while (!mem_req && n < 10);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h0500) begin errors++; $display("FAIL freq_first got addr=%h exp=0500", mem_addr); end
    @(posedge clk); #1 flush = 1'b1; new_pc = 14'h2100;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h0500) begin
      errors++; $display("FAIL freq_drain got req=%b addr=%h exp 1 0500", mem_req, mem_addr);
    end
    @(posedge clk); #1 mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h0500) begin
      errors++; $display("FAIL freq_drain_end got req=%b addr=%h exp 1 0500", mem_req, mem_addr);
    end
    @(posedge clk); #1 mem_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (instr_valid || pc_increment) bad++;
      if (!mem_req) begin @(posedge clk); #1; end
    end while (!mem_req && n < 8);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h2100) begin
      errors++; $display("FAIL freq_refetch got req=%b addr=%h exp 1 2100", mem_req, mem_addr);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL freq_discard got=%0d exp=0", bad); end
    fetch_en = 1'b0;
  endtask

  task automatic test_flush_valid();
    int n = 0;
    apply_reset(14'h0300);
    fetch_en = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h7777; instr_ready = 1'b0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 10);
    @(posedge clk); #1 flush = 1'b1; new_pc = 14'h0400; mem_rdata = 16'h8888;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || pc_increment !== 1'b0) begin
      errors++; $display("FAIL fvld_pulse got vld=%b inc=%b exp 1 0", instr_valid, pc_increment);
    end
    @(posedge clk); #1 flush = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fvld_drop got=%b exp=0", instr_valid); end
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 10);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 14'h0400) begin
      errors++; $display("FAIL fvld_refetch got req=%b addr=%h exp 1 0400", mem_req, mem_addr);
    end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h8888 || pc_increment !== 1'b1) begin
      errors++; $display("FAIL fvld_new got vld=%b instr=%h inc=%b exp 1 8888 1", instr_valid, instr, pc_increment);
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_async_reset();
    int n = 0;
    apply_reset(14'h0010);
    fetch_en = 1'b1; mem_ready = 1'b0; instr_ready = 1'b0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 10);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 14'h0) begin
      errors++; $display("FAIL areset_req got req=%b vld=%b addr=%h exp 0 0 0", mem_req, instr_valid, mem_addr);
    end
    @(posedge clk); #1 rst_n = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 10);
    @(posedge clk); #1;
    checks++; if (instr_valid !== 1'b1 || pc_increment !== 1'b1) begin
      errors++; $display("FAIL areset_pre got vld=%b inc=%b exp 1 1", instr_valid, pc_increment);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc_increment !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0) begin
      errors++; $display("FAIL areset_vld got inc=%b vld=%b instr=%h exp 0 0 0", pc_increment, instr_valid, instr);
    end
    @(posedge clk); #1 rst_n = 1'b1; fetch_en = 1'b0; mem_ready = 1'b0;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_counters();
    int n = 0, accepted = 0;
    apply_reset(14'h0200);
    fetch_en = 1'b1; instr_ready = 1'b1; mem_ready = 1'b0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 10);
    @(posedge clk); #1;
    @(posedge clk); #1 mem_ready = 1'b1;
    n = 0;
    while (accepted < 3 && n < 30) begin
      @(negedge clk); n++;
      if (instr_valid && instr_ready) accepted++;
      @(posedge clk); #1;
    end
    instr_ready = 1'b0; fetch_en = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL perf_fetch got=%0d exp=3", fetch_count); end
    checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL perf_stall got=%0d exp=2", stall_count); end
  endtask
`endif

  task automatic test_random();
    apply_reset(14'h1000);
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      fetch_en    = ($urandom_range(0, 9) != 0);
      flush       = ($urandom_range(0, 11) == 0);
      new_pc      = ADDR_W'($urandom);
      mem_ready   = ($urandom_range(0, 1) == 1);
      mem_rdata   = DATA_W'($urandom);
      instr_ready = ($urandom_range(0, 4) < 3);
      @(negedge clk);
      checks++; if (mem_req !== m_out) begin errors++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", c, mem_req, m_out); end
      if (m_out) begin
        checks++; if (mem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, mem_addr, m_addr); end
      end
      checks++; if (instr_valid !== m_hold) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, instr_valid, m_hold); end
      if (m_hold) begin
        checks++; if (instr !== m_instr) begin errors++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", c, instr, m_instr); end
      end
      checks++; if (pc_increment !== (m_hold && m_first && !flush)) begin
        errors++; $display("FAIL rnd_pulse cyc=%0d got=%b exp=%b", c, pc_increment, (m_hold && m_first && !flush));
      end
    end
    @(posedge clk); #1 flush = 1'b0; fetch_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_mem_stall();
    test_decoder_stall();
    test_flush_req();
    test_flush_valid();
    test_async_reset();
`ifdef FETCH_PERF_CNT_EN
    test_perf_counters();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
